// File: rtl/wb_ex_commit_pkg.sv
// Shared definitions for the writeback/exception-commit stage:
// exception codes, CP0 register addresses and the MEM->WB bus layout.
package wb_ex_commit_pkg;

  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

  typedef struct packed {
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0_addr;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_to_ws_t;

  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);

  // EPC points at the branch for delay-slot instructions; wraps mod 2^32
  function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] pc);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/wb_ex_commit_arbiter.sv
// Exception priority and strobe gating for the WB commit point.
// A taken interrupt overrides any exception carried down the pipe, and any
// exception suppresses the architectural side effects of the instruction.
module wb_ex_arbiter
  import wb_ex_commit_pkg::*;
(
  input  logic       ws_valid,
  input  logic       int_pending,
  input  logic       ex,
  input  logic [4:0] excode,
  input  logic       eret,
  input  logic       mtc0,
  input  logic       gr_we,
  output logic       wb_ex,
  output logic [4:0] wb_excode,
  output logic       eret_flush,
  output logic       mtc0_we,
  output logic       rf_we
);

  logic int_taken;

  // Interrupt wins over latched exception; side effects only without exception
  always_comb begin
    int_taken  = ws_valid & int_pending;
    wb_ex      = ws_valid & (int_taken | ex);
    wb_excode  = int_taken ? EX_INT : excode;
    eret_flush = ws_valid & eret  & ~wb_ex;
    mtc0_we    = ws_valid & mtc0  & ~wb_ex;
    rf_we      = ws_valid & gr_we & ~wb_ex;
  end

endmodule

// File: rtl/wb_ex_commit.sv
// Writeback pipeline register and exception commit point, feeding CP0.
// Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* trace outputs.
module wb_ex_commit
  import wb_ex_commit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_ex,
  input  logic [4:0]  ms_excode,
  input  logic        ms_bd,
  input  logic [31:0] ms_badvaddr,
  input  logic        ms_eret,
  input  logic        ms_mtc0,
  input  logic        ms_mfc0,
  input  logic [7:0]  ms_cp0_addr,
  input  logic [31:0] ms_rt_value,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        int_pending,
  input  logic [31:0] cp0_rdata,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_epc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        mtc0_we,
  output logic [7:0]  cp0_addr,
  output logic [31:0] cp0_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
`ifdef WB_DEBUG_TRACE_EN
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
`endif
  output logic        ws_flush
);

  localparam ms_to_ws_t WS_RESET = '{pc: PC_RESET, default: '0};

  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  ms_to_ws_t                  ws_data_reg;
  logic                       ws_valid_reg;
  logic                       ws_ready_go;

  assign ms_to_ws_bus = {ms_pc, ms_ex, ms_excode, ms_bd, ms_badvaddr, ms_eret,
                         ms_mtc0, ms_mfc0, ms_cp0_addr, ms_rt_value, ms_gr_we,
                         ms_dest, ms_result};

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid_reg | ws_ready_go;

  // Valid bit: a flush kills both the current and the incoming instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_valid_reg <= 1'b0;
    end else if (ws_flush) begin
      ws_valid_reg <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid_reg <= ms_to_ws_valid;
    end
  end

  // Field register: loads only on an accepted, non-flushed handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_data_reg <= WS_RESET;
    end else if (ws_allowin && ms_to_ws_valid && !ws_flush) begin
      ws_data_reg <= ms_to_ws_t'(ms_to_ws_bus);
    end
  end

  wb_ex_arbiter u_arbiter (
    .ws_valid    (ws_valid_reg),
    .int_pending (int_pending),
    .ex          (ws_data_reg.ex),
    .excode      (ws_data_reg.excode),
    .eret        (ws_data_reg.eret),
    .mtc0        (ws_data_reg.mtc0),
    .gr_we       (ws_data_reg.gr_we),
    .wb_ex       (wb_ex),
    .wb_excode   (wb_excode),
    .eret_flush  (eret_flush),
    .mtc0_we     (mtc0_we),
    .rf_we       (rf_we)
  );

  // Data paths toward CP0 and the register file
  always_comb begin
    wb_bd       = ws_data_reg.bd;
    wb_epc      = epc_of(ws_data_reg.bd, ws_data_reg.pc);
    wb_badvaddr = ws_data_reg.badvaddr;
    cp0_addr    = ws_data_reg.cp0_addr;
    cp0_wdata   = ws_data_reg.rt_value;
    rf_waddr    = ws_data_reg.dest;
    rf_wdata    = ws_data_reg.mfc0 ? cp0_rdata : ws_data_reg.result;
    ws_flush    = wb_ex | eret_flush;
  end

`ifdef WB_DEBUG_TRACE_EN
  // Trace view of the commit; PC is masked so it reads 0 while in reset
  always_comb begin
    debug_wb_pc       = reset ? ws_data_reg.pc : 32'd0;
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`endif

endmodule
